// File: rtl/pattern_scan_unit.sv
// Memory-mapped pattern-search co-processor: counts 5-bit pattern hits over a
// 32-byte string and writes the three counts back beside the pattern byte.
module pattern_scan_unit #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wen,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [7:0]    ctb,
    output logic [7:0]    cto,
    output logic [7:0]    cts
);

    typedef enum logic [2:0] {
        IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE
    } state_t;

    localparam logic [AW-1:0] STR_ADDR = AW'(BASE_ADDR);
    localparam logic [AW-1:0] PAT_ADDR = AW'(BASE_ADDR + 32);
    localparam logic [AW-1:0] CTB_ADDR = AW'(BASE_ADDR + 33);
    localparam logic [AW-1:0] CTO_ADDR = AW'(BASE_ADDR + 34);
    localparam logic [AW-1:0] CTS_ADDR = AW'(BASE_ADDR + 35);

    state_t        state_q, state_d;
    logic          go_q, go_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    pat_q, pat_d;
    logic [3:0]    prev4_q, prev4_d;
    logic [7:0]    ctb_q, ctb_d;
    logic [7:0]    cto_q, cto_d;
    logic [7:0]    cts_q, cts_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [11:0]   win;
    logic [7:0]    hit;
    logic [3:0]    ctb_inc;
    logic [3:0]    cts_inc;

    // Window b covers win[b+4:b]; b=0..3 lie inside the current byte,
    // b=4..7 straddle the previous byte and only count once idx > 0.
    always_comb begin
        win     = {prev4_q, mem_rdata};
        hit     = '0;
        ctb_inc = '0;
        cts_inc = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            hit[b] = (win[b +: 5] == pat_q);
        end
        for (int unsigned b = 0; b < 4; b++) begin
            ctb_inc = ctb_inc + 4'(hit[b]);
        end
        for (int unsigned b = 0; b < 8; b++) begin
            if (b < 4 || idx_q != '0) begin
                cts_inc = cts_inc + 4'(hit[b]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        prev4_d = prev4_q;
        ctb_d   = ctb_q;
        cto_d   = cto_q;
        cts_d   = cts_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            // Start is registered for one cycle so no output depends on it
            // combinationally; LDPAT therefore begins one edge after start.
            IDLE, DONE: begin
                if (go_q) begin
                    go_d    = 1'b0;
                    state_d = LDPAT;
                    addr_d  = PAT_ADDR;
                    busy_d  = 1'b1;
                end else if (start) begin
                    go_d   = 1'b1;
                    idx_d  = '0;
                    ctb_d  = '0;
                    cto_d  = '0;
                    cts_d  = '0;
                    done_d = 1'b0;
                end
            end
            LDPAT: begin
                pat_d   = mem_rdata[7:3];
                prev4_d = '0;
                addr_d  = STR_ADDR;
                state_d = SCAN;
            end
            SCAN: begin
                ctb_d   = ctb_q + {4'b0000, ctb_inc};
                cto_d   = cto_q + {7'b0000000, (ctb_inc != '0)};
                cts_d   = cts_q + {4'b0000, cts_inc};
                prev4_d = mem_rdata[3:0];
                if (idx_q == 5'd31) begin
                    state_d = WR0;
                    addr_d  = CTB_ADDR;
                    wen_d   = 1'b1;
                    wdata_d = ctb_d;
                end else begin
                    idx_d  = idx_q + 5'd1;
                    addr_d = STR_ADDR + AW'(idx_q) + AW'(1);
                end
            end
            WR0: begin
                state_d = WR1;
                addr_d  = CTO_ADDR;
                wen_d   = 1'b1;
                wdata_d = cto_q;
            end
            WR1: begin
                state_d = WR2;
                addr_d  = CTS_ADDR;
                wen_d   = 1'b1;
                wdata_d = cts_q;
            end
            WR2: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            idx_q   <= '0;
            pat_q   <= '0;
            prev4_q <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            prev4_q <= prev4_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ctb       = ctb_q;
    assign cto       = cto_q;
    assign cts       = cts_q;

endmodule
